// File: rtl/fifo_status.sv
// fifo_status: full/empty/level from the FIFO pointers plus registered thresholds, error flags and peak watermark.
// Latency: full/empty/level combinational; almost flags, error flags and peak_level one cycle. No backpressure (observer only).
// FIFO_STICKY_ERR_EN: overflow/underflow held until clr_stat or reset; otherwise single-cycle pulses.
module fifo_status #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic [ADDR_WIDTH:0]   rptr,
    input  logic                  i_wr,
    input  logic                  i_rd,
    input  logic                  clr_stat,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow,
    output logic [ADDR_WIDTH:0]   peak_level
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_level;
    logic          w_ovf_evt;
    logic          w_unf_evt;

    logic          r_af;
    logic          r_ae;
    logic          r_ovf;
    logic          r_unf;
    logic [PW-1:0] r_peak;

    // Modular subtraction keeps the level correct across the wrap bit.
    assign w_level   = wptr - rptr;
    assign w_empty   = (wptr == rptr);
    assign w_full    = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                       (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign w_ovf_evt = i_wr & w_full;
    assign w_unf_evt = i_rd & w_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_af <= 1'b0;
            r_ae <= 1'b1;
        end else begin
            r_af <= (w_level >= AF_THR);
            r_ae <= (w_level <= AE_THR);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            // A fresh event beats a same-cycle clear.
            r_ovf <= w_ovf_evt | (r_ovf & ~clr_stat);
            r_unf <= w_unf_evt | (r_unf & ~clr_stat);
`else
            r_ovf <= w_ovf_evt;
            r_unf <= w_unf_evt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_peak <= '0;
        end else if (clr_stat) begin
            r_peak <= w_level;
        end else if (w_level > r_peak) begin
            r_peak <= w_level;
        end
    end

    assign fifo_full         = w_full;
    assign fifo_empty        = w_empty;
    assign fifo_level        = w_level;
    assign fifo_almost_full  = r_af;
    assign fifo_almost_empty = r_ae;
    assign fifo_overflow     = r_ovf;
    assign fifo_underflow    = r_unf;
    assign peak_level        = r_peak;

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status (ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2); expected registered outputs queued per cycle.
module tb_fifo_status;

    logic       clk;
    logic       rstn;
    logic [3:0] wptr;
    logic [3:0] rptr;
    logic       i_wr;
    logic       i_rd;
    logic       clr_stat;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_level;
    logic       fifo_almost_full;
    logic       fifo_almost_empty;
    logic       fifo_overflow;
    logic       fifo_underflow;
    logic [3:0] peak_level;

    fifo_status #(.ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .wptr              (wptr),
        .rptr              (rptr),
        .i_wr              (i_wr),
        .i_rd              (i_rd),
        .clr_stat          (clr_stat),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_level        (fifo_level),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow),
        .peak_level        (peak_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic [3:0] peak;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    // Model of the expected registered state after the last edge.
    logic       m_ovf  = 1'b0;
    logic       m_unf  = 1'b0;
    logic [3:0] m_peak = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive pointers/requests at posedge+1, check combinational
    // flags, queue the registered expectation, then compare it after the edge.
    task automatic cycle(input logic [3:0] w, input logic [3:0] r,
                         input logic wr, input logic rd, input logic clr);
        logic [3:0] lvl;
        logic       full;
        logic       empty;
        logic       ovf_evt;
        logic       unf_evt;
        exp_t       e;
        exp_t       got;
        wptr = w; rptr = r; i_wr = wr; i_rd = rd; clr_stat = clr;
        #1;
        lvl   = w - r;
        empty = (w == r);
        full  = (w[3] != r[3]) && (w[2:0] == r[2:0]);
        chk("level", 32'(fifo_level), 32'(lvl));
        chk("full",  32'(fifo_full),  32'(full));
        chk("empty", 32'(fifo_empty), 32'(empty));
        ovf_evt = wr & full;
        unf_evt = rd & empty;
        e.af = (lvl >= 4'd6);
        e.ae = (lvl <= 4'd2);
`ifdef FIFO_STICKY_ERR_EN
        e.ovf = ovf_evt | (m_ovf & ~clr);
        e.unf = unf_evt | (m_unf & ~clr);
`else
        e.ovf = ovf_evt;
        e.unf = unf_evt;
`endif
        if (clr)              e.peak = lvl;
        else if (lvl > m_peak) e.peak = lvl;
        else                  e.peak = m_peak;
        m_ovf = e.ovf; m_unf = e.unf; m_peak = e.peak;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = q.pop_front();
            chk("almost_full",  32'(fifo_almost_full),  32'(got.af));
            chk("almost_empty", 32'(fifo_almost_empty), 32'(got.ae));
            chk("overflow",     32'(fifo_overflow),     32'(got.ovf));
            chk("underflow",    32'(fifo_underflow),    32'(got.unf));
            chk("peak_level",   32'(peak_level),        32'(got.peak));
        end
    endtask

    task automatic chk_reset_regs(input string tag);
        chk({tag, "_af"},   32'(fifo_almost_full),  32'd0);
        chk({tag, "_ae"},   32'(fifo_almost_empty), 32'd1);
        chk({tag, "_ovf"},  32'(fifo_overflow),     32'd0);
        chk({tag, "_unf"},  32'(fifo_underflow),    32'd0);
        chk({tag, "_peak"}, 32'(peak_level),        32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] w;
        logic [3:0] r;
        rstn = 1'b0; wptr = 4'd0; rptr = 4'd0;
        i_wr = 1'b0; i_rd = 1'b0; clr_stat = 1'b0;
        #12;
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full",  32'(fifo_full),  32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk_reset_regs("rst");
        @(posedge clk); #1;
        rstn = 1'b1;
        chk_reset_regs("rel");

        // Underflow from the reset state, then idle and clear.
        cycle(4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        cycle(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Fill: level 0..7 with writes, then a write at level 8 overflows.
        for (int i = 0; i < 8; i++) cycle(4'(i), 4'd0, 1'b1, 1'b0, 1'b0);
        cycle(4'd8, 4'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(4'd8, 4'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd8, 4'd0, 1'b0, 1'b0, 1'b1);
        cycle(4'd8, 4'd0, 1'b0, 1'b0, 1'b0);

        // Clear and overflow in the same cycle: event wins, peak reloads 8.
        cycle(4'd8, 4'd0, 1'b1, 1'b0, 1'b1);
        cycle(4'd8, 4'd0, 1'b0, 1'b0, 1'b0);

        // Interleaved drain/fill to wptr=13, rptr=10.
        w = 4'd8;
        for (int i = 1; i <= 10; i++) begin
            r = 4'(i);
            if (i <= 5) w = 4'(8 + i);
            cycle(w, r, (i <= 5), 1'b1, 1'b0);
        end
        cycle(4'b1101, 4'b1010, 1'b0, 1'b0, 1'b0);
        cycle(4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0);
        cycle(4'b0110, 4'b1001, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with an overflow event pending.
        wptr = 4'd8; rptr = 4'd0; i_wr = 1'b1; i_rd = 1'b0; clr_stat = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_regs("midrst");
        wptr = 4'd0; i_wr = 1'b0;
        @(posedge clk); #1;
        chk_reset_regs("midrst_hold");
        rstn = 1'b1;
        m_ovf = 1'b0; m_unf = 1'b0; m_peak = 4'd0;
        q.delete();
        cycle(4'd3, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_status.md
# fifo_status

Status and flag generator for the synchronous FIFO. Sits between the write-pointer and read-pointer stages. It consumes both pointers and produces the `fifo_full`/`fifo_empty` flags that gate those stages. It also provides occupancy level, registered almost-full/almost-empty thresholds, overflow/underflow error flags and a peak-occupancy watermark for the top module.

## Interface
- `ADDR_WIDTH`, default 3: FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (MSB is the wrap bit).
- `AF_LEVEL`, default 6: almost-full asserts when level >= AF_LEVEL; legal range 1..2^ADDR_WIDTH.
- `AE_LEVEL`, default 2: almost-empty asserts when level <= AE_LEVEL; legal range 0..2^ADDR_WIDTH-1.

Ports:
- `clk` in 1: the single clock; all registers are rising-edge.
- `rstn` in 1: asynchronous, active-low reset.
- `wptr` in ADDR_WIDTH+1: registered write pointer from the write-pointer stage.
- `rptr` in ADDR_WIDTH+1: registered read pointer from the read-pointer stage.
- `i_wr` in 1: raw write request from the top module.
- `i_rd` in 1: raw read request from the top module.
- `clr_stat` in 1: synchronous clear of the error flags and the peak watermark.
- `fifo_full` out 1: combinational full flag.
- `fifo_empty` out 1: combinational empty flag.
- `fifo_level` out ADDR_WIDTH+1: combinational occupancy, 0..2^ADDR_WIDTH.
- `fifo_almost_full` out 1: registered threshold flag.
- `fifo_almost_empty` out 1: registered threshold flag.
- `fifo_overflow` out 1: registered error flag.
- `fifo_underflow` out 1: registered error flag.
- `peak_level` out ADDR_WIDTH+1: registered maximum of `fifo_level` since reset or the last clear.

## Operation
- `fifo_empty` = (`wptr` == `rptr`).
- `fifo_full` = (`wptr`[MSB] != `rptr`[MSB]) and (`wptr`[ADDR_WIDTH-1:0] == `rptr`[ADDR_WIDTH-1:0]).
- `fifo_level` = (`wptr` - `rptr`) modulo 2^(ADDR_WIDTH+1).
  - Correct across pointer wrap, e.g. ADDR_WIDTH=3, `wptr`=4'b0001, `rptr`=4'b1110 gives level 3.
  - Full gives exactly 2^ADDR_WIDTH; empty gives 0.
- `fifo_almost_full` register: loads (`fifo_level` >= AF_LEVEL) every cycle.
- `fifo_almost_empty` register: loads (`fifo_level` <= AE_LEVEL) every cycle.
- Overflow event: `i_wr` & `fifo_full` at a clock edge.
  - Counts even when a read occurs in the same cycle. The write is blocked upstream because full is sampled pre-edge.
- Underflow event: `i_rd` & `fifo_empty` at a clock edge.
  - Counts even when a write occurs in the same cycle.
- `peak_level`: loads `fifo_level` when `fifo_level` > `peak_level`.
- `clr_stat` clears `fifo_overflow`, `fifo_underflow` and `peak_level`.
  - A new event in the same cycle as `clr_stat` wins: the flag is set.
  - `peak_level` loads the current `fifo_level` instead of 0.
- This block only observes the pointers; it never modifies them.

## Timing
- Reset (`rstn` low, asynchronous, takes effect immediately):
  - `fifo_almost_full`=0, `fifo_almost_empty`=1, `fifo_overflow`=0, `fifo_underflow`=0, `peak_level`=0.
  - Combinational outputs follow the pointers, which reset to 0: `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0.
- Full, empty and level: zero latency relative to the pointers, i.e. they valid in the same cycle the pointers update.
- Almost-full/almost-empty, error flags and watermark: one-cycle latency after the pointer change or request that caused them.
- Reset mid-operation: all registered outputs return to their reset values in the same cycle; no pending event survives.
- Release of `rstn` is synchronized externally; this block needs no recovery handling.

## Configuration
- Macro: `FIFO_STICKY_ERR_EN`.
- Defined: `fifo_overflow`/`fifo_underflow` are sticky; they remain 1 until `clr_stat` or reset.
- Undefined: each flag is a single-cycle registered pulse, 1 in the cycle after each event and 0 otherwise.
  - `clr_stat` then affects only `peak_level`.

## Test plan
All scenarios use ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2.
- Reset with `rstn`=0, then release:
  - `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0, `fifo_almost_empty`=1, all other registered outputs 0.
- 8 consecutive writes, no reads:
  - `fifo_level` steps 0..8.
  - `fifo_almost_full` rises one cycle after level reaches 6.
  - `fifo_full`=1 at level 8.
  - `peak_level`=8.
- Write while full with `i_wr`=1:
  - `fifo_overflow`=1 the next cycle.
  - Sticky build: stays 1 for 10 further cycles, clears one cycle after a `clr_stat` pulse.
  - Non-sticky build: back to 0 after one cycle.
- Read while empty with `i_rd`=1 at reset state: `fifo_underflow`=1 the next cycle.
- Wrap-around: 13 writes and 10 reads interleaved, so `wptr`=4'b1101 and `rptr`=4'b1010:
  - `fifo_level`=3, `fifo_full`=0, `fifo_empty`=0.
- Simultaneous `clr_stat` and overflow event while full: `fifo_overflow`=1 next cycle, `peak_level`=8.
